// File: rtl/ram_ctrl_pkg.sv
// Shared types for the RAM access controller: default widths, FSM states
// and the queued request payload.
package ram_ctrl_pkg;

  localparam int unsigned RAM_ADDR_W = 12;
  localparam int unsigned RAM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    CAP  = 2'd3
  } state_e;

  typedef struct packed {
    logic                  rw;
    logic [RAM_ADDR_W-1:0] addr;
    logic [RAM_DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/ram4096X16.sv
// Behavioural single-port 4096x16 RAM: write on rising edge when rw=1,
// asynchronous read driven onto the shared bus when rw=0.
module ram4096X16 (
  input  logic        clk,
  input  logic        rw,
  input  logic [11:0] addr,
  inout  wire  [15:0] data
);

  logic [15:0] mem [4096];

  always_ff @(posedge clk) begin
    if (rw) mem[addr] <= data;
  end

  assign data = rw ? 16'bz : mem[addr];

endmodule

// File: rtl/ram_req_fifo.sv
// Request queue: synchronous write, combinational head read, flags derived
// from the registered occupancy count.
module ram_req_fifo #(
  parameter int unsigned W     = 29,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] head_c_o,
  output logic         full_c_o,
  output logic         empty_c_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_c_o  = (count_q == CNT_W'(DEPTH));
  assign empty_c_o = (count_q == '0);
  assign do_push   = push_i && !full_c_o;
  assign do_pop    = pop_i && !empty_c_o;
  assign head_c_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// Queued read/write controller for a single-port RAM with a shared data bus.
// Define RAM_ACCESS_CTRL_STATS_EN to build the accepted-request counters.
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = RAM_ADDR_W,
  parameter int unsigned DATA_W     = RAM_DATA_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count
);

  localparam int unsigned REQ_W = 1 + ADDR_W + DATA_W;

  state_e              state_q, state_d;
  logic                ram_rw_q, ram_rw_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [ADDR_W-1:0]   rsp_addr_q, rsp_addr_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic [REQ_W-1:0]    head;
  logic                head_rw;
  logic [ADDR_W-1:0]   head_addr;
  logic [DATA_W-1:0]   head_wdata;
  logic                full, empty, push, pop;

  assign req_ready  = !full;
  assign push       = req_valid && !full;
  assign head_rw    = head[REQ_W-1];
  assign head_addr  = head[DATA_W +: ADDR_W];
  assign head_wdata = head[DATA_W-1:0];

  ram_req_fifo #(
    .W     (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push),
    .din_i     ({req_rw, req_addr, req_wdata}),
    .pop_i     (pop),
    .head_c_o  (head),
    .full_c_o  (full),
    .empty_c_o (empty)
  );

  // Bus outputs are computed for the state being entered so they leave flops.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    ram_rw_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_addr_d  = rsp_addr_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      RD: state_d = CAP;
      default: begin
        if (!empty) begin
          pop        = 1'b1;
          ram_addr_d = head_addr;
          if (head_rw) begin
            state_d  = WR;
            ram_rw_d = 1'b1;
            wdata_d  = head_wdata;
          end else begin
            state_d  = RD;
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
    if (state_q == CAP) begin
      rsp_valid_d = 1'b1;
      rsp_addr_d  = ram_addr_q;
      rsp_rdata_d = ram_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ram_rw_q    <= 1'b0;
      ram_addr_q  <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ram_rw_q    <= ram_rw_d;
      ram_addr_q  <= ram_addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // One flop gates both the write strobe and the bus driver.
  assign ram_data  = ram_rw_q ? wdata_q : {DATA_W{1'bz}};
  assign ram_rw    = ram_rw_q;
  assign ram_addr  = ram_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_rdata = rsp_rdata_q;

`ifdef RAM_ACCESS_CTRL_STATS_EN
  logic [15:0] wr_cnt_q, rd_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else if (push) begin
      if (req_rw && (wr_cnt_q != 16'hFFFF))  wr_cnt_q <= wr_cnt_q + 16'd1;
      if (!req_rw && (rd_cnt_q != 16'hFFFF)) rd_cnt_q <= rd_cnt_q + 16'd1;
    end
  end

  assign wr_count = wr_cnt_q;
  assign rd_count = rd_cnt_q;
`else
  assign wr_count = '0;
  assign rd_count = '0;
`endif

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Scoreboard bench for ram_access_ctrl driving a ram4096X16 model.
module tb_ram_access_ctrl;
  import ram_ctrl_pkg::*;

  typedef struct {
    logic [11:0] addr;
    logic [15:0] data;
    bit          chk_lat;
    int          lat_cyc;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_rw = 1'b0;
  logic [11:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic [11:0] rsp_addr;
  logic [15:0] rsp_rdata;
  logic        ram_rw;
  logic [11:0] ram_addr;
  wire  [15:0] ram_data;
  logic [15:0] wr_count, rd_count;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_wr    = 0;
  int n_rd    = 0;
  bit gap_chk = 1'b0;
  bit lat_next = 1'b0;

  rd_exp_t     rdq[$];
  req_t        wrq[$];
  logic [15:0] model [4096];

  ram_access_ctrl #(.ADDR_W(12), .DATA_W(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata),
    .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_data(ram_data),
    .wr_count(wr_count), .rd_count(rd_count)
  );

  ram4096X16 u_ram (.clk(clk), .rw(ram_rw), .addr(ram_addr), .data(ram_data));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Response and write-bus monitor; responses must arrive in request order.
  int  last_rsp_cyc = 0;
  bit  gap_seen = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid) begin
        if (rdq.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
        else begin
          rd_exp_t e;
          e = rdq.pop_front();
          check("rsp_addr", 32'(rsp_addr), 32'(e.addr));
          check("rsp_rdata", 32'(rsp_rdata), 32'(e.data));
          if (e.chk_lat) check("rsp_latency", 32'(cyc), 32'(e.lat_cyc));
        end
        if (gap_chk && gap_seen) check("rsp_gap", 32'(cyc - last_rsp_cyc), 32'd2);
        last_rsp_cyc = cyc;
        gap_seen = gap_chk;
      end else if (!gap_chk) begin
        gap_seen = 1'b0;
      end
      if (ram_rw) begin
        if (wrq.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
        else begin
          req_t w;
          w = wrq.pop_front();
          check("wr_addr", 32'(ram_addr), 32'(w.addr));
          check("wr_bus", 32'(ram_data), 32'(w.wdata));
        end
      end
    end
  end

  // Offer one request; returns the number of edges it was held off.
  task automatic send(input logic rw, input logic [11:0] a, input logic [15:0] d,
                      output int stalls);
    bit acc;
    int c0;
    acc = 1'b0;
    stalls = 0;
    c0 = 0;
    req_valid = 1'b1;
    req_rw    = rw;
    req_addr  = a;
    req_wdata = d;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = req_ready;
      c0 = cyc;
      @(posedge clk);
      if (!acc) stalls++;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
    else if (rw) begin
      wrq.push_back('{rw: 1'b1, addr: a, wdata: d});
      model[a] = d;
      n_wr++;
    end else begin
      rdq.push_back('{addr: a, data: model[a], chk_lat: lat_next, lat_cyc: c0 + 4});
      n_rd++;
    end
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (rdq.size() != 0 || wrq.size() != 0); i++) @(negedge clk);
    check("drain_done", 32'(rdq.size() + wrq.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    rdq.delete();
    wrq.delete();
    n_wr = 0;
    n_rd = 0;
    check("rst_ram_rw", 32'(ram_rw), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_addr", 32'(rsp_addr), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_wr_count", 32'(wr_count), 32'd0);
    check("rst_rd_count", 32'(rd_count), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int st;
    int tot;
    logic [11:0] a;
    logic [15:0] d;

    #2;
    do_reset();

    // Write sweep then read back in reversed bank order.
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 4; j++) begin
        a = 12'((j << 10) | k);
        send(1'b1, a, 16'((j << 10) | k), st);
      end
    for (int k = 1; k <= 4; k++)
      for (int j = 3; j >= 0; j--) begin
        a = 12'((j << 10) | k);
        send(1'b0, a, 16'h0, st);
      end
    idle();
    drain();

    // Overwrite and confirm new data is returned.
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 4; j++) begin
        a = 12'((j << 10) | k);
        d = 16'((k << 8) | (j * 4));
        send(1'b1, a, d, st);
      end
    for (int k = 3; k >= 0; k--)
      for (int j = 3; j >= 0; j--) begin
        a = 12'((j << 10) | k);
        send(1'b0, a, 16'h0, st);
      end
    idle();
    drain();

    // Backpressure: valid held across 8 reads from an idle controller.
    gap_chk = 1'b1;
    tot = 0;
    for (int k = 0; k < 7; k++) begin
      send(1'b0, 12'((1 << 10) | k), 16'h0, st);
      tot += st;
    end
    check("bp_no_stall_first7", 32'(tot), 32'd0);
    send(1'b0, 12'h407, 16'h0, st);
    check("bp_stall_8th", 32'(st), 32'd1);
    idle();
    drain();
    gap_chk = 1'b0;

    // Mixed: write then immediate read of the same address.
    send(1'b1, 12'h123, 16'hBEEF, st);
    lat_next = 1'b1;
    send(1'b0, 12'h123, 16'h0, st);
    lat_next = 1'b0;
    idle();
    drain();

    // Reset while a read of 12'h004 sits in CAP.
    send(1'b0, 12'h004, 16'h0, st);
    idle();
    @(posedge clk);
    @(posedge clk);
    #2;
    check("cap_ram_rw", 32'(ram_rw), 32'd0);
    check("cap_ram_addr", 32'(ram_addr), 32'h004);
    do_reset();
    repeat (4) @(posedge clk);
    #1;
    send(1'b0, 12'h004, 16'h0, st);
    idle();
    drain();

    // Statistics from a clean reset.
    do_reset();
    for (int k = 0; k < 5; k++) send(1'b1, 12'(12'h200 + k), 16'(16'hA000 + k), st);
    for (int k = 0; k < 3; k++) send(1'b0, 12'(12'h200 + k), 16'h0, st);
    idle();
    drain();
`ifdef RAM_ACCESS_CTRL_STATS_EN
    check("wr_count", 32'(wr_count), 32'd5);
    check("rd_count", 32'(rd_count), 32'd3);
`else
    check("wr_count", 32'(wr_count), 32'd0);
    check("rd_count", 32'(rd_count), 32'd0);
`endif
    check("stats_n_wr", 32'(n_wr), 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
